execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 16-bit, 8-register pipelined processor.
- Consumes decoded ID/EX fields, resolves operand forwarding from the MEM and WB stages, and runs the ALU.
- Ops: ADD, SUB, AND, OR, XOR, SLT, SLTU, PASSB.
- Registers the result into the EX/MEM pipeline register consumed by the memory stage; propagates HALT and holds a sticky halted flag.

Parameters:
- DataWidth, 16, operand/result width.
- RegAddrBits, 3, register address width (8 registers).
- AluOpBits, 3, ALU opcode width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- id_valid  in  1  ID/EX slot holds a real instruction.
- id_alu_op  in  AluOpBits  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 PASSB.
- id_rs_addr, id_rt_addr  in  RegAddrBits  source register numbers.
- id_rs_val, id_rt_val  in  DataWidth  register-file read data.
- id_imm  in  DataWidth  sign-extended immediate.
- id_use_imm  in  1  B operand = id_imm instead of rt.
- id_rd_addr  in  RegAddrBits  destination.
- id_reg_write  in  1  instruction writes rd.
- id_halt  in  1  instruction is HALT.
- mem_fwd_we, mem_fwd_rd, mem_fwd_val  in  1/RegAddrBits/DataWidth  EX/MEM-stage writeback candidate.
- wb_fwd_we, wb_fwd_rd, wb_fwd_val  in  1/RegAddrBits/DataWidth  MEM/WB-stage writeback candidate.
- stall  in  1  hold the EX/MEM register.
- flush  in  1  kill the instruction entering EX/MEM.
- ex_valid  out  1  EX/MEM valid.
- ex_result  out  DataWidth  registered ALU result.
- ex_rd_addr  out  RegAddrBits  registered rd.
- ex_reg_write  out  1  registered write enable (forced 0 when invalid).
- ex_halt  out  1  registered HALT marker.
- halted  out  1  sticky; set once HALT leaves EX.

Behaviour:
- Reset (RST=1 at posedge): all outputs 0, including halted. RST has priority over stall and flush.
- Latency: one cycle, ID/EX inputs to ex_* outputs.
- Forwarding, combinational per source operand (rs, and rt when id_use_imm=0):
  - Priority 1: mem_fwd_we && mem_fwd_rd==addr && addr!=0 → mem_fwd_val.
  - Priority 2: else the same test on WB → wb_fwd_val.
  - Priority 3: else the register-file value.
  - Register 0 is never forwarded and always reads 0.
- ALU (A = forwarded rs; B = imm or forwarded rt):
  - ADD/SUB: modulo 2^DataWidth.
  - SLT: 1 if $signed(A) < $signed(B), else 0; result zero-extended.
  - SLTU: unsigned compare.
  - PASSB: B.
- Update rule at posedge:
  - stall=1: all ex_* hold.
  - else flush=1 or id_valid=0 or halted=1: ex_valid, ex_reg_write, ex_halt ← 0. ex_result and ex_rd_addr keep their values (don't-care).
  - else: capture the ALU result and control fields. ex_reg_write ← id_reg_write && id_rd_addr!=0.
- Halt:
  - halted sets on the cycle after ex_valid && ex_halt, if not stalled.
  - Once halted=1, no further valid instruction is issued until RST.
  - A HALT captured into EX/MEM never writes rd.
- Simultaneous stall+flush: stall wins, and the flush is lost. The hazard unit must not assert both.
- Reset mid-program clears halted and the pipeline register in the same edge.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined:
  - Extra output ex_ovf (1 bit), registered alongside ex_result.
  - ex_ovf = signed overflow for ADD/SUB, 0 for all other ops.
  - ex_ovf is cleared on reset, flush, and invalid slots.
- Undefined: the port does not exist and there is no overflow logic.

Decomposition:
- Shared package/header pipeline_defs holds:
  - ALU opcode localparams (ALU_ADD…ALU_PASSB).
  - DataWidth and RegAddrBits defaults.
  - REG_ZERO constant.
- One sub-module: alu_16, purely combinational, taking (op, a, b) and returning (result, ovf).
- Forward muxes and the pipeline register stay in execute_stage.

Test Plan:
- SLT with back-to-back forwarding:
  - Stimulus: ADDI $1 = 0xFFFF, then ADDI $2 = 0x0003, then SLT $3,$1,$2 and SLT $4,$2,$1, with producers driven on the mem_fwd/wb_fwd ports.
  - Response: ex_result = 0x0001, then 0x0000.
  - SLT $5,$1,$1 → 0x0000.
  - SLTU $1,$2 → 0x0000.
- Forward priority:
  - Stimulus: MEM and WB both target rs=3 (0x1111 vs 0x2222); ADD with rt=$0.
  - Response: result 0x1111. With rd=0 on both ports, the regfile value is used.
- Stall/flush:
  - Stimulus: stall high for 2 cycles.
  - Response: ex_* unchanged.
  - Stimulus: flush with id_valid=1, reg_write=1.
  - Response: ex_valid=0, ex_reg_write=0.
- Halt:
  - Stimulus: HALT, then ADD.
  - Response: ex_halt=1 for one cycle; halted=1 on the next edge; the following ADD gives ex_valid=0.
  - Stimulus: RST for one cycle.
  - Response: halted=0.
- Write to $0:
  - Stimulus: ADDI $0,$0,5.
  - Response: ex_reg_write=0.
- ALU_OVF_EN build:
  - Stimulus: ADD 0x7FFF + 0x0001.
  - Response: ex_result=0x8000, ex_ovf=1.
  - Stimulus: SUB 0x8000 − 0x0001.
  - Response: ex_ovf=1.
  - Stimulus: AND.
  - Response: ex_ovf=0.

Source files
------------

// File: rtl/pipeline_defs_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_defs_pkg
// Shared definitions for the 16-bit, 8-register pipelined processor:
//   - default operand width and register-address width
//   - ALU opcode encodings (ALU_ADD .. ALU_PASSB)
//   - REG_ZERO, the hard-wired zero register number
// No ports (package).
// ----------------------------------------------------------------------------
package pipeline_defs_pkg;

    localparam int DATA_WIDTH_DEF    = 16;
    localparam int REG_ADDR_BITS_DEF = 3;
    localparam int ALU_OP_BITS       = 3;

    localparam logic [ALU_OP_BITS-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALU_OP_BITS-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALU_OP_BITS-1:0] ALU_AND   = 3'd2;
    localparam logic [ALU_OP_BITS-1:0] ALU_OR    = 3'd3;
    localparam logic [ALU_OP_BITS-1:0] ALU_XOR   = 3'd4;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLT   = 3'd5;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLTU  = 3'd6;
    localparam logic [ALU_OP_BITS-1:0] ALU_PASSB = 3'd7;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/alu_16.sv
// ----------------------------------------------------------------------------
// alu_16
// Purely combinational ALU for the EX stage.
// Ports:
//   i_op      ALU opcode (see pipeline_defs_pkg)
//   i_a       operand A (forwarded rs)
//   i_b       operand B (immediate or forwarded rt)
//   o_result  ALU result
//   o_ovf     signed overflow for ADD/SUB, 0 otherwise; only computed when
//             ALU_OVF_EN is defined, tied to 0 otherwise
// Optional feature macro: ALU_OVF_EN
// ----------------------------------------------------------------------------
module alu_16
    import pipeline_defs_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH_DEF
) (
    input  logic [ALU_OP_BITS-1:0] i_op,
    input  logic [DataWidth-1:0]   i_a,
    input  logic [DataWidth-1:0]   i_b,
    output logic [DataWidth-1:0]   o_result,
    output logic                   o_ovf
);

    logic signed [DataWidth-1:0] w_a_s;
    logic signed [DataWidth-1:0] w_b_s;
    logic [DataWidth-1:0]        w_sum;
    logic [DataWidth-1:0]        w_diff;
    logic                        w_slt;
    logic                        w_sltu;

    assign w_a_s  = i_a;
    assign w_b_s  = i_b;
    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_slt  = (w_a_s < w_b_s);
    assign w_sltu = (i_a < i_b);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:   o_result = w_sum;
            ALU_SUB:   o_result = w_diff;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SLT:   o_result = {{(DataWidth-1){1'b0}}, w_slt};
            ALU_SLTU:  o_result = {{(DataWidth-1){1'b0}}, w_sltu};
            ALU_PASSB: o_result = i_b;
            default:   o_result = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    // Overflow: operands of like sign (ADD) or unlike sign (SUB) producing
    // a result whose sign differs from A.
    always_comb begin
        o_ovf = 1'b0;
        case (i_op)
            ALU_ADD: o_ovf = (i_a[DataWidth-1] == i_b[DataWidth-1]) &&
                             (w_sum[DataWidth-1] != i_a[DataWidth-1]);
            ALU_SUB: o_ovf = (i_a[DataWidth-1] != i_b[DataWidth-1]) &&
                             (w_diff[DataWidth-1] != i_a[DataWidth-1]);
            default: o_ovf = 1'b0;
        endcase
    end
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
// EX stage of the 16-bit, 8-register pipelined processor. Resolves operand
// forwarding from MEM and WB, runs the ALU (alu_16) and registers the result
// into the EX/MEM pipeline register. Tracks a sticky halted flag.
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   id_*                     decoded ID/EX fields (valid, op, rs/rt addr+data,
//                            imm, use_imm, rd, reg_write, halt)
//   mem_fwd_we/rd/val        MEM-stage writeback candidate (highest priority)
//   wb_fwd_we/rd/val         WB-stage writeback candidate
//   stall                    hold EX/MEM register
//   flush                    kill the instruction entering EX/MEM
//   ex_valid/result/rd_addr/reg_write/halt   EX/MEM register outputs
//   halted                   sticky, set once a HALT leaves EX
//   ex_ovf                   (ALU_OVF_EN only) registered signed overflow
// Optional feature macro: ALU_OVF_EN
// ----------------------------------------------------------------------------
module execute_stage
    import pipeline_defs_pkg::*;
#(
    parameter int DataWidth   = DATA_WIDTH_DEF,
    parameter int RegAddrBits = REG_ADDR_BITS_DEF,
    parameter int AluOpBits   = ALU_OP_BITS
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   id_valid,
    input  logic [AluOpBits-1:0]   id_alu_op,
    input  logic [RegAddrBits-1:0] id_rs_addr,
    input  logic [RegAddrBits-1:0] id_rt_addr,
    input  logic [DataWidth-1:0]   id_rs_val,
    input  logic [DataWidth-1:0]   id_rt_val,
    input  logic [DataWidth-1:0]   id_imm,
    input  logic                   id_use_imm,
    input  logic [RegAddrBits-1:0] id_rd_addr,
    input  logic                   id_reg_write,
    input  logic                   id_halt,
    input  logic                   mem_fwd_we,
    input  logic [RegAddrBits-1:0] mem_fwd_rd,
    input  logic [DataWidth-1:0]   mem_fwd_val,
    input  logic                   wb_fwd_we,
    input  logic [RegAddrBits-1:0] wb_fwd_rd,
    input  logic [DataWidth-1:0]   wb_fwd_val,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   ex_valid,
    output logic [DataWidth-1:0]   ex_result,
    output logic [RegAddrBits-1:0] ex_rd_addr,
    output logic                   ex_reg_write,
    output logic                   ex_halt,
`ifdef ALU_OVF_EN
    output logic                   ex_ovf,
`endif
    output logic                   halted
);

    localparam logic [RegAddrBits-1:0] ZERO_ADDR = RegAddrBits'(REG_ZERO);

    // MEM beats WB beats register file; register 0 always reads as zero.
    function automatic logic [DataWidth-1:0] fwd_operand(
        input logic [RegAddrBits-1:0] addr,
        input logic [DataWidth-1:0]   rf_val,
        input logic                   m_we,
        input logic [RegAddrBits-1:0] m_rd,
        input logic [DataWidth-1:0]   m_val,
        input logic                   w_we,
        input logic [RegAddrBits-1:0] w_rd,
        input logic [DataWidth-1:0]   w_val
    );
        logic [DataWidth-1:0] v;
        if (addr == ZERO_ADDR)
            v = '0;
        else if (m_we && (m_rd == addr))
            v = m_val;
        else if (w_we && (w_rd == addr))
            v = w_val;
        else
            v = rf_val;
        return v;
    endfunction

    logic [DataWidth-1:0] w_op_a_p0;
    logic [DataWidth-1:0] w_rt_fwd_p0;
    logic [DataWidth-1:0] w_op_b_p0;
    logic [DataWidth-1:0] w_alu_res_p0;
    logic                 w_alu_ovf_p0;
    logic                 w_halting;
    logic                 w_kill;

    assign w_op_a_p0   = fwd_operand(id_rs_addr, id_rs_val,
                                     mem_fwd_we, mem_fwd_rd, mem_fwd_val,
                                     wb_fwd_we, wb_fwd_rd, wb_fwd_val);
    assign w_rt_fwd_p0 = fwd_operand(id_rt_addr, id_rt_val,
                                     mem_fwd_we, mem_fwd_rd, mem_fwd_val,
                                     wb_fwd_we, wb_fwd_rd, wb_fwd_val);
    assign w_op_b_p0   = id_use_imm ? id_imm : w_rt_fwd_p0;

    alu_16 #(
        .DataWidth (DataWidth)
    ) u_alu (
        .i_op     (id_alu_op),
        .i_a      (w_op_a_p0),
        .i_b      (w_op_b_p0),
        .o_result (w_alu_res_p0),
        .o_ovf    (w_alu_ovf_p0)
    );

    // A HALT sitting in EX/MEM already counts as halting, so the very next
    // instruction is not issued while halted is being set.
    assign w_halting = halted | (ex_valid & ex_halt);
    assign w_kill    = flush | ~id_valid | w_halting;

    // ---- EX/MEM pipeline register (stage p1) ----
    logic                   r_vld_p1;
    logic [DataWidth-1:0]   r_result_p1;
    logic [RegAddrBits-1:0] r_rd_p1;
    logic                   r_rw_p1;
    logic                   r_halt_p1;
    logic                   r_ovf_p1;
    logic                   r_halted;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld_p1    <= 1'b0;
            r_result_p1 <= '0;
            r_rd_p1     <= '0;
            r_rw_p1     <= 1'b0;
            r_halt_p1   <= 1'b0;
            r_ovf_p1    <= 1'b0;
            r_halted    <= 1'b0;
        end else if (!stall) begin
            if (r_vld_p1 && r_halt_p1)
                r_halted <= 1'b1;
            if (w_kill) begin
                r_vld_p1  <= 1'b0;
                r_rw_p1   <= 1'b0;
                r_halt_p1 <= 1'b0;
                r_ovf_p1  <= 1'b0;
            end else begin
                r_vld_p1    <= 1'b1;
                r_result_p1 <= w_alu_res_p0;
                r_rd_p1     <= id_rd_addr;
                r_rw_p1     <= id_reg_write && (id_rd_addr != ZERO_ADDR) && !id_halt;
                r_halt_p1   <= id_halt;
                r_ovf_p1    <= w_alu_ovf_p0;
            end
        end
    end

    assign ex_valid     = r_vld_p1;
    assign ex_result    = r_result_p1;
    assign ex_rd_addr   = r_rd_p1;
    assign ex_reg_write = r_rw_p1;
    assign ex_halt      = r_halt_p1;
    assign halted       = r_halted;
`ifdef ALU_OVF_EN
    assign ex_ovf       = r_ovf_p1;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = r_ovf_p1;
`endif

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
    import pipeline_defs_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid;
    logic [2:0]  id_alu_op;
    logic [2:0]  id_rs_addr, id_rt_addr;
    logic [15:0] id_rs_val, id_rt_val, id_imm;
    logic        id_use_imm;
    logic [2:0]  id_rd_addr;
    logic        id_reg_write, id_halt;
    logic        mem_fwd_we;
    logic [2:0]  mem_fwd_rd;
    logic [15:0] mem_fwd_val;
    logic        wb_fwd_we;
    logic [2:0]  wb_fwd_rd;
    logic [15:0] wb_fwd_val;
    logic        stall, flush;
    logic        ex_valid;
    logic [15:0] ex_result;
    logic [2:0]  ex_rd_addr;
    logic        ex_reg_write, ex_halt, halted;
`ifdef ALU_OVF_EN
    logic        ex_ovf;
`endif

    execute_stage dut (
        .CLK          (CLK),
        .RST          (RST),
        .id_valid     (id_valid),
        .id_alu_op    (id_alu_op),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_rs_val    (id_rs_val),
        .id_rt_val    (id_rt_val),
        .id_imm       (id_imm),
        .id_use_imm   (id_use_imm),
        .id_rd_addr   (id_rd_addr),
        .id_reg_write (id_reg_write),
        .id_halt      (id_halt),
        .mem_fwd_we   (mem_fwd_we),
        .mem_fwd_rd   (mem_fwd_rd),
        .mem_fwd_val  (mem_fwd_val),
        .wb_fwd_we    (wb_fwd_we),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_val   (wb_fwd_val),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_result    (ex_result),
        .ex_rd_addr   (ex_rd_addr),
        .ex_reg_write (ex_reg_write),
        .ex_halt      (ex_halt),
`ifdef ALU_OVF_EN
        .ex_ovf       (ex_ovf),
`endif
        .halted       (halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        vld;
        logic [2:0]  op;
        logic [2:0]  rs, rt;
        logic [15:0] rsv, rtv, imm;
        logic        use_imm;
        logic [2:0]  rd;
        logic        rw;
        logic        mwe;
        logic [2:0]  mrd;
        logic [15:0] mval;
        logic        wwe;
        logic [2:0]  wrd;
        logic [15:0] wval;
        logic        e_vld;
        logic [15:0] e_res;
        logic        e_rw;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(
        input string n, input logic v, input logic [2:0] op,
        input logic [2:0] rs, input logic [2:0] rt,
        input logic [15:0] rsv, input logic [15:0] rtv, input logic [15:0] imm,
        input logic ui, input logic [2:0] rd, input logic rw,
        input logic mwe, input logic [2:0] mrd, input logic [15:0] mval,
        input logic wwe, input logic [2:0] wrd, input logic [15:0] wval,
        input logic ev, input logic [15:0] eres, input logic erw);
        vec_t t;
        t.name = n; t.vld = v; t.op = op; t.rs = rs; t.rt = rt;
        t.rsv = rsv; t.rtv = rtv; t.imm = imm; t.use_imm = ui;
        t.rd = rd; t.rw = rw; t.mwe = mwe; t.mrd = mrd; t.mval = mval;
        t.wwe = wwe; t.wrd = wrd; t.wval = wval;
        t.e_vld = ev; t.e_res = eres; t.e_rw = erw;
        return t;
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", n, act, exp);
    endtask

    task automatic apply(input vec_t v);
        id_valid = v.vld; id_alu_op = v.op; id_rs_addr = v.rs; id_rt_addr = v.rt;
        id_rs_val = v.rsv; id_rt_val = v.rtv; id_imm = v.imm; id_use_imm = v.use_imm;
        id_rd_addr = v.rd; id_reg_write = v.rw;
        mem_fwd_we = v.mwe; mem_fwd_rd = v.mrd; mem_fwd_val = v.mval;
        wb_fwd_we = v.wwe; wb_fwd_rd = v.wrd; wb_fwd_val = v.wval;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; stall = 1'b0; flush = 1'b0; id_halt = 1'b0;
        apply(mk("idle", 0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick(); tick();
        chk("rst_valid", 16'(ex_valid), 16'h0);
        chk("rst_result", ex_result, 16'h0);
        chk("rst_rd", 16'(ex_rd_addr), 16'h0);
        chk("rst_rw", 16'(ex_reg_write), 16'h0);
        chk("rst_halt", 16'(ex_halt), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        RST = 1'b0;

        //            name        v op         rs rt rsv      rtv      imm      ui rd rw mwe mrd mval     wwe wrd wval     ev res      rw
        vecs.push_back(mk("addi1",     1, ALU_ADD,   0, 0, 16'h1234, 16'h0000, 16'hFFFF, 1, 1, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'hFFFF, 1));
        vecs.push_back(mk("addi2",     1, ALU_ADD,   0, 0, 16'h0000, 16'h0000, 16'h0003, 1, 2, 1, 1, 1, 16'hFFFF, 0, 0, 16'h0,    1, 16'h0003, 1));
        vecs.push_back(mk("slt_fwd1",  1, ALU_SLT,   1, 2, 16'h0000, 16'h0000, 16'h0000, 0, 3, 1, 1, 2, 16'h0003, 1, 1, 16'hFFFF, 1, 16'h0001, 1));
        vecs.push_back(mk("slt_fwd2",  1, ALU_SLT,   2, 1, 16'h0000, 16'hFFFF, 16'h0000, 0, 4, 1, 1, 3, 16'h0001, 1, 2, 16'h0003, 1, 16'h0000, 1));
        vecs.push_back(mk("slt_same",  1, ALU_SLT,   1, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 5, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0000, 1));
        vecs.push_back(mk("sltu_f",    1, ALU_SLTU,  1, 2, 16'hFFFF, 16'h0003, 16'h0000, 0, 6, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0000, 1));
        vecs.push_back(mk("sltu_t",    1, ALU_SLTU,  2, 1, 16'h0003, 16'hFFFF, 16'h0000, 0, 7, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0001, 1));
        vecs.push_back(mk("slt_min",   1, ALU_SLT,   1, 2, 16'h8000, 16'h7FFF, 16'h0000, 0, 3, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0001, 1));
        vecs.push_back(mk("sltu_min",  1, ALU_SLTU,  1, 2, 16'h8000, 16'h7FFF, 16'h0000, 0, 3, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0000, 1));
        vecs.push_back(mk("fwd_pri",   1, ALU_ADD,   3, 0, 16'h3333, 16'h5555, 16'h0000, 0, 5, 1, 1, 3, 16'h1111, 1, 3, 16'h2222, 1, 16'h1111, 1));
        vecs.push_back(mk("fwd_rd0",   1, ALU_ADD,   3, 0, 16'h3333, 16'h5555, 16'h0000, 0, 5, 1, 1, 0, 16'h1111, 1, 0, 16'h2222, 1, 16'h3333, 1));
        vecs.push_back(mk("fwd_wb",    1, ALU_ADD,   3, 0, 16'h3333, 16'h0000, 16'h0000, 0, 5, 1, 1, 4, 16'h1111, 1, 3, 16'h2222, 1, 16'h2222, 1));
        vecs.push_back(mk("fwd_we0",   1, ALU_ADD,   3, 0, 16'h3333, 16'h0000, 16'h0000, 0, 5, 1, 0, 3, 16'h1111, 0, 3, 16'h2222, 1, 16'h3333, 1));
        vecs.push_back(mk("r0_nofwd",  1, ALU_ADD,   0, 0, 16'h1111, 16'h2222, 16'h0000, 0, 6, 1, 1, 0, 16'h7777, 1, 0, 16'h8888, 1, 16'h0000, 1));
        vecs.push_back(mk("rt_imm",    1, ALU_ADD,   1, 3, 16'h0010, 16'h0000, 16'h0005, 1, 2, 1, 1, 3, 16'h1111, 0, 0, 16'h0,    1, 16'h0015, 1));
        vecs.push_back(mk("rt_fwd",    1, ALU_ADD,   1, 3, 16'h0010, 16'h0000, 16'h0005, 0, 2, 1, 1, 3, 16'h1111, 0, 0, 16'h0,    1, 16'h1121, 1));
        vecs.push_back(mk("sub",       1, ALU_SUB,   1, 2, 16'h0005, 16'h0007, 16'h0000, 0, 2, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'hFFFE, 1));
        vecs.push_back(mk("and",       1, ALU_AND,   1, 2, 16'hF0F0, 16'h3C3C, 16'h0000, 0, 3, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h3030, 1));
        vecs.push_back(mk("or",        1, ALU_OR,    1, 2, 16'hF0F0, 16'h3C3C, 16'h0000, 0, 4, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'hFCFC, 1));
        vecs.push_back(mk("xor",       1, ALU_XOR,   1, 2, 16'hF0F0, 16'h3C3C, 16'h0000, 0, 5, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'hCCCC, 1));
        vecs.push_back(mk("passb",     1, ALU_PASSB, 1, 2, 16'h1234, 16'h0000, 16'hABCD, 1, 6, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'hABCD, 1));
        vecs.push_back(mk("add_wrap",  1, ALU_ADD,   1, 2, 16'hFFFF, 16'h0002, 16'h0000, 0, 7, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0001, 1));
        vecs.push_back(mk("wr_r0",     1, ALU_ADD,   0, 0, 16'h0000, 16'h0000, 16'h0005, 1, 0, 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0005, 0));
        vecs.push_back(mk("no_rw",     1, ALU_ADD,   1, 2, 16'h0001, 16'h0001, 16'h0000, 0, 3, 0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0002, 0));
        vecs.push_back(mk("invalid",   0, ALU_ADD,   1, 2, 16'h0001, 16'h0001, 16'h0000, 0, 3, 1, 0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            tick();
            chk({vecs[i].name, "_valid"}, 16'(ex_valid), 16'(vecs[i].e_vld));
            chk({vecs[i].name, "_rw"}, 16'(ex_reg_write), 16'(vecs[i].e_rw));
            if (vecs[i].e_vld) begin
                chk({vecs[i].name, "_result"}, ex_result, vecs[i].e_res);
                chk({vecs[i].name, "_rd"}, 16'(ex_rd_addr), 16'(vecs[i].rd));
            end
        end

        // Stall holds EX/MEM for two cycles, stall beats flush, then flush kills.
        apply(mk("ld", 1, ALU_ADD, 1, 0, 16'h0040, 0, 16'h0002, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("stall_pre_result", ex_result, 16'h0042);
        apply(mk("other", 1, ALU_SUB, 1, 0, 16'h0009, 0, 16'h0001, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("stall_result", ex_result, 16'h0042);
            chk("stall_rd", 16'(ex_rd_addr), 16'd5);
            chk("stall_valid", 16'(ex_valid), 16'h1);
        end
        flush = 1'b1;
        tick();
        chk("stallflush_valid", 16'(ex_valid), 16'h1);
        chk("stallflush_result", ex_result, 16'h0042);
        stall = 1'b0;
        tick();
        chk("flush_valid", 16'(ex_valid), 16'h0);
        chk("flush_rw", 16'(ex_reg_write), 16'h0);
        flush = 1'b0;
        tick();
        chk("postflush_result", ex_result, 16'h0008);
        chk("postflush_valid", 16'(ex_valid), 16'h1);

        // HALT, then ADD: ADD must not issue; RST clears halted.
        apply(mk("halt", 1, ALU_ADD, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        id_halt = 1'b1;
        tick();
        chk("halt_exhalt", 16'(ex_halt), 16'h1);
        chk("halt_valid", 16'(ex_valid), 16'h1);
        chk("halt_rw", 16'(ex_reg_write), 16'h0);
        chk("halt_halted0", 16'(halted), 16'h0);
        id_halt = 1'b0;
        apply(mk("add", 1, ALU_ADD, 1, 0, 16'h0004, 0, 16'h0004, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("halted_set", 16'(halted), 16'h1);
        chk("after_halt_valid", 16'(ex_valid), 16'h0);
        chk("after_halt_exhalt", 16'(ex_halt), 16'h0);
        tick();
        chk("halted_sticky", 16'(halted), 16'h1);
        chk("halted_valid", 16'(ex_valid), 16'h0);
        RST = 1'b1;
        tick();
        chk("rst_clr_halted", 16'(halted), 16'h0);
        chk("rst_clr_valid", 16'(ex_valid), 16'h0);
        RST = 1'b0;
        tick();
        chk("resume_valid", 16'(ex_valid), 16'h1);
        chk("resume_result", ex_result, 16'h0008);

`ifdef ALU_OVF_EN
        apply(mk("ovf_add", 1, ALU_ADD, 1, 2, 16'h7FFF, 16'h0001, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("ovf_add_result", ex_result, 16'h8000);
        chk("ovf_add", 16'(ex_ovf), 16'h1);
        apply(mk("ovf_sub", 1, ALU_SUB, 1, 2, 16'h8000, 16'h0001, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("ovf_sub_result", ex_result, 16'h7FFF);
        chk("ovf_sub", 16'(ex_ovf), 16'h1);
        apply(mk("ovf_and", 1, ALU_AND, 1, 2, 16'h7FFF, 16'h7FFF, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("ovf_and", 16'(ex_ovf), 16'h0);
        apply(mk("ovf_add2", 1, ALU_ADD, 1, 2, 16'h7FFF, 16'h0001, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        flush = 1'b1;
        tick();
        chk("ovf_flush", 16'(ex_ovf), 16'h0);
        flush = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
